// File: rtl/serial_frame_tx_if.sv
// Parallel-load / serial-out bundle between a frame source and the serial transmitter.
interface serial_frame_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d;
  logic             ld;
  logic             tx;
  logic             busy;
  logic             done;

  modport master (output d, ld, input tx, busy, done);
  modport slave  (input d, ld, output tx, busy, done);
endinterface

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, data LSB first, optional even parity, stop bit.
// All state moves on the falling edge of c; every output comes straight from a flop.
//
// state | meaning
// IDLE  | line high, waiting for ld
// START | line low for one bit period
// DATA  | shifting out the latched word, LSB first
// PAR   | even-parity bit of the latched word
// STOP  | line high for one bit period, done in its last cycle
module serial_frame_tx #(
  parameter int WIDTH  = 8,
  parameter int DIV    = 16,
  parameter int PARITY = 0
) (
  input  logic               c,
  input  logic               re_,
  serial_frame_tx_if.slave   bus
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state_q, state_n;
  logic [DCW-1:0]   div_q, div_n;
  logic [BCW-1:0]   bit_q, bit_n;
  logic [WIDTH-1:0] sh_q, sh_n;
  logic             par_q, par_n;
  logic             tx_q, tx_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             div_last;

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_n = state_q;
    div_n   = div_q;
    bit_n   = bit_q;
    sh_n    = sh_q;
    par_n   = par_q;
    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          state_n = START;
          div_n   = '0;
          sh_n    = bus.d;
          par_n   = ^bus.d;
        end
      end
      START: begin
        if (div_last) begin
          div_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      DATA: begin
        if (div_last) begin
          div_n = '0;
          sh_n  = sh_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_n   = '0;
            state_n = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      PAR: begin
        if (div_last) begin
          div_n   = '0;
          state_n = STOP;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      STOP: begin
        if (div_last) begin
          div_n   = '0;
          state_n = IDLE;
        end else begin
          div_n = div_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops with zero extra latency.
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      PAR:     tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
    done_n = (state_n == STOP) && (div_n == DIV_LAST);
  end

  always_ff @(negedge c) begin
    if (!re_) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      bit_q   <= bit_n;
      sh_q    <= sh_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: four parameterisations sharing one clock and reset.
module tb_serial_frame_tx;

  typedef struct {
    logic       rb;
    logic       ld;
    logic [7:0] d;
    logic       tx;
    logic       busy;
    logic       done;
  } vec_t;

  logic       c = 1'b1;
  logic       re_ = 1'b0;
  logic       ld_r = 1'b0;
  logic [7:0] d_r = 8'h00;
  int         sel = 0;
  logic       obs_tx, obs_busy, obs_done;
  int         checks = 0;
  int         errors = 0;
  vec_t       tbl[$];

  always #5 c = ~c;

  serial_frame_tx_if #(.WIDTH(8)) if_basic ();
  serial_frame_tx_if #(.WIDTH(8)) if_par ();
  serial_frame_tx_if #(.WIDTH(8)) if_b2b ();
  serial_frame_tx_if #(.WIDTH(1)) if_w1 ();

  assign if_basic.ld = (sel == 0) && ld_r;
  assign if_par.ld   = (sel == 1) && ld_r;
  assign if_b2b.ld   = (sel == 2) && ld_r;
  assign if_w1.ld    = (sel == 3) && ld_r;
  assign if_basic.d  = d_r;
  assign if_par.d    = d_r;
  assign if_b2b.d    = d_r;
  assign if_w1.d     = d_r[0];

  serial_frame_tx #(.WIDTH(8), .DIV(4), .PARITY(0)) u_basic (.c(c), .re_(re_), .bus(if_basic));
  serial_frame_tx #(.WIDTH(8), .DIV(2), .PARITY(1)) u_par   (.c(c), .re_(re_), .bus(if_par));
  serial_frame_tx #(.WIDTH(8), .DIV(1), .PARITY(0)) u_b2b   (.c(c), .re_(re_), .bus(if_b2b));
  serial_frame_tx #(.WIDTH(1), .DIV(1), .PARITY(0)) u_w1    (.c(c), .re_(re_), .bus(if_w1));

  always_comb begin
    obs_tx   = 1'b1;
    obs_busy = 1'b0;
    obs_done = 1'b0;
    case (sel)
      0: begin obs_tx = if_basic.tx; obs_busy = if_basic.busy; obs_done = if_basic.done; end
      1: begin obs_tx = if_par.tx;   obs_busy = if_par.busy;   obs_done = if_par.done;   end
      2: begin obs_tx = if_b2b.tx;   obs_busy = if_b2b.busy;   obs_done = if_b2b.done;   end
      default: begin obs_tx = if_w1.tx; obs_busy = if_w1.busy; obs_done = if_w1.done; end
    endcase
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs are set after a rising edge, sampled by the DUT on the falling edge,
  // and the registered outputs are read back on the following rising edge.
  task automatic step(input logic rb, input logic l, input logic [7:0] dv,
                      input logic etx, input logic ebusy, input logic edone, input string nm);
    re_  = rb;
    ld_r = l;
    d_r  = dv;
    @(negedge c);
    @(posedge c);
    chk({nm, ".tx"},   obs_tx,   etx);
    chk({nm, ".busy"}, obs_busy, ebusy);
    chk({nm, ".done"}, obs_done, edone);
  endtask

  // bits[0] is the first bit on the line; d switches to d_mid from the 5th cycle of the frame.
  task automatic add_frame(input logic [19:0] bits, input int nbits, input int div,
                           input logic [7:0] dv, input logic hold, input logic [7:0] d_mid);
    vec_t v;
    for (int k = 0; k < nbits * div; k++) begin
      v.rb   = 1'b1;
      v.ld   = (k == 0) ? 1'b1 : hold;
      v.d    = (k >= 4) ? d_mid : dv;
      v.tx   = bits[k / div];
      v.busy = 1'b1;
      v.done = (k == nbits * div - 1);
      tbl.push_back(v);
    end
    v.rb   = 1'b1;
    v.ld   = hold;
    v.d    = d_mid;
    v.tx   = 1'b1;
    v.busy = 1'b0;
    v.done = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rb, tbl[i].ld, tbl[i].d, tbl[i].tx, tbl[i].busy, tbl[i].done,
           $sformatf("%s[%0d]", name, i));
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "reset_hold");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, "reset_release");

    sel = 0;
    add_frame({1'b1, 8'hA5, 1'b0}, 10, 4, 8'hA5, 1'b0, 8'h5A);
    tbl.push_back('{rb: 1'b1, ld: 1'b0, d: 8'h00, tx: 1'b1, busy: 1'b0, done: 1'b0});
    run_table("basic");

    sel = 1;
    add_frame({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 2, 8'hA5, 1'b0, 8'hFF);
    add_frame({1'b1, 1'b1, 8'h07, 1'b0}, 11, 2, 8'h07, 1'b0, 8'h00);
    run_table("parity");

    sel = 2;
    add_frame({1'b1, 8'h3C, 1'b0}, 10, 1, 8'h3C, 1'b1, 8'hC3);
    add_frame({1'b1, 8'hC3, 1'b0}, 10, 1, 8'hC3, 1'b0, 8'hC3);
    run_table("b2b");

    sel = 3;
    add_frame({1'b1, 1'b1, 1'b0}, 3, 1, 8'h01, 1'b0, 8'h00);
    run_table("w1");

    // Reset during the third data bit of 8'h5A, whose bit 2 is 0, so the line visibly returns high.
    sel = 0;
    step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, "mf_start");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, "mf_start");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, "mf_bit0");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, "mf_bit1");
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, "mf_bit2");
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, "mf_reset");
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, "mf_quiet");
    add_frame({1'b1, 8'hA5, 1'b0}, 10, 4, 8'hA5, 1'b0, 8'h00);
    run_table("mf_clean");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Serial frame transmitter: accepts a parallel word on a load strobe and shifts it out on a single line. The frame is a start bit, then data LSB first, then an optional even-parity bit, then a stop bit. Each bit is held for a programmable number of clock cycles. It is the sending end for the flip-flop-based serial capture path in the lab datapath.

## Interface
- WIDTH, 8: data word width; valid range 1–16.
- DIV, 16: clock cycles per serial bit; valid range 1–256.
- PARITY, 0: 0 means no parity bit; 1 means an even-parity bit is inserted after the data.
- c  input  1  clock; all state updates on the falling edge of c.
- re_  input  1  synchronous active-low reset, sampled on the falling edge of c.
- d  input  WIDTH  parallel word to send.
- ld  input  1  load strobe.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse on the final cycle of the stop bit.

## Operation
- **States:** IDLE, START, DATA, PAR, STOP.
- **Reset (re_ low at an edge):** next state IDLE, tx=1, busy=0, done=0. Shift register and counters clear to 0. ld is ignored while re_ is low.
- **IDLE:**
  - tx=1, busy=0.
  - On ld=1, latch d into the shift register and go to START.
  - On ld=0, stay in IDLE.
- **START:** tx=0 for DIV cycles, then go to DATA.
- **DATA:**
  - tx = shift register bit 0.
  - At the end of each DIV-cycle bit period, shift right and increment the bit counter.
  - After WIDTH bits, go to PAR if PARITY=1, otherwise go to STOP.
- **PAR:** tx = XOR of the latched word, computed at load time. tx is held for DIV cycles, then go to STOP.
- **STOP:** tx=1 for DIV cycles. done=1 only in the last of those cycles. Then go to IDLE.
- **busy:** 1 in START, DATA, PAR and STOP.
- **ld while busy=1:** ignored. The latched word is unaffected.
- **Changes to d after load:** no effect on the frame in progress.
- **Divide counter:**
  - Counts 0..DIV-1 and wraps to 0 at each bit boundary.
  - When DIV=1, every cycle is a bit boundary.
  - Counter width is ceil(log2(DIV)), with a minimum of 1.
- **Bit counter:** counts 0..WIDTH-1 and resets to 0 on entry to DATA.

## Timing
- **Load to line:** ld sampled high at edge k in IDLE gives tx=0 and busy=1 from edge k onward (first START cycle). Latency is 1 edge.
- **Frame length:** (WIDTH+2+PARITY)·DIV cycles from the first START cycle to the last STOP cycle inclusive.
- **Back-to-back frames:**
  - busy falls at the edge after the last STOP cycle.
  - ld held high continuously starts the next frame one edge after busy falls.
  - The minimum inter-frame gap is therefore exactly 1 idle cycle with tx=1.
- **Reset mid-frame:** takes effect at the sampling edge. tx returns high at once, the partial frame is abandoned, and no done pulse is generated.
- **ld and re_ low at the same edge:** reset wins and no frame starts.
- **Output registration:** all outputs are registered, with no combinational path from d, ld or re_ to any output.

## Test plan
- **Reset values:** hold re_=0 for 3 cycles with ld=1 and d=8'hFF. Required: tx=1, busy=0, done=0 throughout; no frame after re_ rises unless ld is sampled high again.
- **Basic frame (WIDTH=8, DIV=4, PARITY=0):**
  - Stimulus: pulse ld with d=8'hA5.
  - Required tx bit sequence, each bit 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - busy high for 40 cycles; done high only in cycle 40.
- **Parity (PARITY=1, DIV=2):**
  - Stimulus: d=8'hA5, then d=8'h07.
  - Required parity bit: 0 for 8'hA5 and 1 for 8'h07.
  - Frame length 22 cycles each.
- **Back-to-back and busy load (DIV=1):**
  - Stimulus: hold ld=1 with d=8'h3C, change d to 8'hC3 mid-frame.
  - Required: first frame carries 8'h3C; one idle-high cycle; second frame carries 8'hC3.
  - ld during busy does not corrupt either frame.
- **Reset mid-frame (DIV=4):** assert re_=0 during the 3rd data bit of a frame. Required: tx=1 and busy=0 after the sampling edge, no done pulse, and a clean new frame on the next ld.
- **Boundary widths:** WIDTH=1, DIV=1, d=1'b1. Required tx sequence 0,1,1 over 3 cycles, with done in the 3rd.
